// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl: single-session ATM controller with an NUM_ACC-entry
// account table (account, PIN, balance, valid, lock, fail count), PIN retry
// lockout, idle timeout and a valid/ready command handshake.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   prov_*_i              table provisioning (honoured in IDLE only)
//   card_valid_i/acc_i    card presentation (honoured in IDLE only)
//   pin_valid_i/pin_i     PIN entry (honoured in GET_PIN only)
//   cmd_*_i, cmd_ready_o  command handshake (ready in MENU only)
//   exit_i                session abort
//   rsp_*_o               registered response strobe, status and balance
//   session_active_o      high while a card session is open
module atm_session_ctrl #(
  parameter int unsigned NUM_ACC     = 10,
  parameter int unsigned ACC_W       = 12,
  parameter int unsigned PIN_W       = 4,
  parameter int unsigned BAL_W       = 16,
  parameter int unsigned IDX_W       = 4,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned IDLE_CYCLES = 1000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             prov_en_i,
  input  logic [IDX_W-1:0] prov_idx_i,
  input  logic [ACC_W-1:0] prov_acc_i,
  input  logic [PIN_W-1:0] prov_pin_i,
  input  logic [BAL_W-1:0] prov_bal_i,
  input  logic             card_valid_i,
  input  logic [ACC_W-1:0] card_acc_i,
  input  logic             pin_valid_i,
  input  logic [PIN_W-1:0] pin_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [2:0]       cmd_op_i,
  input  logic [BAL_W-1:0] cmd_amount_i,
  input  logic [ACC_W-1:0] cmd_dest_i,
  input  logic             exit_i,
  output logic             rsp_valid_o,
  output logic [2:0]       rsp_status_o,
  output logic [BAL_W-1:0] rsp_balance_o,
  output logic             session_active_o
);

  localparam int unsigned FAIL_W = $clog2(MAX_TRIES + 1);
  localparam int unsigned CNT_W  = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;

  localparam logic [2:0] ST_OK        = 3'd0;
  localparam logic [2:0] ST_INSUFF    = 3'd1;
  localparam logic [2:0] ST_OVERFLOW  = 3'd2;
  localparam logic [2:0] ST_NO_DEST   = 3'd3;
  localparam logic [2:0] ST_BAD_OP    = 3'd4;
  localparam logic [2:0] ST_AUTH_FAIL = 3'd5;
  localparam logic [2:0] ST_LOCKED    = 3'd6;
  localparam logic [2:0] ST_TIMEOUT   = 3'd7;

  localparam logic [2:0] OP_BALANCE  = 3'd0;
  localparam logic [2:0] OP_WITHDRAW = 3'd1;
  localparam logic [2:0] OP_DEPOSIT  = 3'd2;
  localparam logic [2:0] OP_TRANSFER = 3'd3;
  localparam logic [2:0] OP_LOGOUT   = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GET_PIN = 2'd1,
    S_MENU    = 2'd2,
    S_EXEC    = 2'd3
  } state_e;

  // Account table: data fields carry no reset, control bits do.
  logic [ACC_W-1:0]               acc_q [NUM_ACC];
  logic [PIN_W-1:0]               pin_q [NUM_ACC];
  logic [BAL_W-1:0]               bal_q [NUM_ACC];
  logic [NUM_ACC-1:0]             valid_q;
  logic [NUM_ACC-1:0]             lock_q;
  logic [NUM_ACC-1:0][FAIL_W-1:0] fail_q;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] sess_idx_q, sess_idx_d;
  logic [2:0]       op_q, op_d;
  logic [BAL_W-1:0] amt_q, amt_d;
  logic [ACC_W-1:0] dest_q, dest_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [2:0]       rsp_status_q, rsp_status_d;
  logic [BAL_W-1:0] rsp_balance_q, rsp_balance_d;
  logic             cmd_ready_q;
  logic             sess_act_q;

  // Table update controls from the FSM
  logic             prov_we;
  logic             fail_clr;
  logic             fail_inc;
  logic             lock_set;
  logic             src_we;
  logic [BAL_W-1:0] src_bal_d;
  logic             dst_we;
  logic [BAL_W-1:0] dst_bal_d;

  // Lookup results
  logic             card_hit;
  logic [IDX_W-1:0] card_idx;
  logic             dest_hit;
  logic [IDX_W-1:0] dest_idx;

  // EXEC datapath
  logic [BAL_W-1:0] sess_bal;
  logic [BAL_W-1:0] dst_bal;
  logic [BAL_W:0]   dep_sum;
  logic [BAL_W:0]   xfer_sum;
  logic             short_funds;
  logic             timeout_hit;

  // Table search; scanning downwards lets the lowest matching index win.
  always_comb begin
    card_hit = 1'b0;
    card_idx = '0;
    dest_hit = 1'b0;
    dest_idx = '0;
    for (int i = int'(NUM_ACC) - 1; i >= 0; i--) begin
      if (valid_q[IDX_W'(i)] && (acc_q[IDX_W'(i)] == card_acc_i)) begin
        card_hit = 1'b1;
        card_idx = IDX_W'(i);
      end
      if (valid_q[IDX_W'(i)] && (acc_q[IDX_W'(i)] == dest_q)) begin
        dest_hit = 1'b1;
        dest_idx = IDX_W'(i);
      end
    end
  end

  // Arithmetic for the latched command, carry bit kept for overflow checks
  always_comb begin
    sess_bal    = bal_q[sess_idx_q];
    dst_bal     = bal_q[dest_idx];
    dep_sum     = {1'b0, sess_bal} + {1'b0, amt_q};
    xfer_sum    = {1'b0, dst_bal} + {1'b0, amt_q};
    short_funds = (amt_q > sess_bal);
    timeout_hit = (cnt_q == CNT_W'(IDLE_CYCLES - 1));
  end

  // Next-state, response and table-control logic
  always_comb begin
    state_d       = state_q;
    sess_idx_d    = sess_idx_q;
    op_d          = op_q;
    amt_d         = amt_q;
    dest_d        = dest_q;
    cnt_d         = '0;
    rsp_valid_d   = 1'b0;
    rsp_status_d  = rsp_status_q;
    rsp_balance_d = rsp_balance_q;
    prov_we       = 1'b0;
    fail_clr      = 1'b0;
    fail_inc      = 1'b0;
    lock_set      = 1'b0;
    src_we        = 1'b0;
    src_bal_d     = sess_bal;
    dst_we        = 1'b0;
    dst_bal_d     = dst_bal;

    case (state_q)
      S_IDLE: begin
        if (prov_en_i) begin
          prov_we = (32'(prov_idx_i) < NUM_ACC);
        end else if (card_valid_i) begin
          if (!card_hit) begin
            rsp_valid_d  = 1'b1;
            rsp_status_d = ST_AUTH_FAIL;
          end else if (lock_q[card_idx]) begin
            rsp_valid_d  = 1'b1;
            rsp_status_d = ST_LOCKED;
          end else begin
            sess_idx_d = card_idx;
            state_d    = S_GET_PIN;
          end
        end
      end

      S_GET_PIN: begin
        if (exit_i) begin
          rsp_valid_d  = 1'b1;
          rsp_status_d = ST_OK;
          state_d      = S_IDLE;
        end else if (pin_valid_i) begin
          rsp_valid_d = 1'b1;
          if (pin_i == pin_q[sess_idx_q]) begin
            fail_clr      = 1'b1;
            rsp_status_d  = ST_OK;
            rsp_balance_d = sess_bal;
            state_d       = S_MENU;
          end else if (fail_q[sess_idx_q] == FAIL_W'(MAX_TRIES - 1)) begin
            lock_set     = 1'b1;
            rsp_status_d = ST_LOCKED;
            state_d      = S_IDLE;
          end else begin
            fail_inc     = 1'b1;
            rsp_status_d = ST_AUTH_FAIL;
          end
        end else if (timeout_hit) begin
          rsp_valid_d  = 1'b1;
          rsp_status_d = ST_TIMEOUT;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_MENU: begin
        if (exit_i) begin
          rsp_valid_d  = 1'b1;
          rsp_status_d = ST_OK;
          state_d      = S_IDLE;
        end else if (cmd_valid_i) begin
          op_d    = cmd_op_i;
          amt_d   = cmd_amount_i;
          dest_d  = cmd_dest_i;
          state_d = S_EXEC;
        end else if (timeout_hit) begin
          rsp_valid_d  = 1'b1;
          rsp_status_d = ST_TIMEOUT;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_EXEC: begin
        rsp_valid_d   = 1'b1;
        rsp_status_d  = ST_OK;
        rsp_balance_d = sess_bal;
        state_d       = S_MENU;
        case (op_q)
          OP_BALANCE: ;
          OP_WITHDRAW: begin
            if (short_funds) begin
              rsp_status_d = ST_INSUFF;
            end else begin
              src_we        = 1'b1;
              src_bal_d     = sess_bal - amt_q;
              rsp_balance_d = sess_bal - amt_q;
            end
          end
          OP_DEPOSIT: begin
            if (dep_sum[BAL_W]) begin
              rsp_status_d = ST_OVERFLOW;
            end else begin
              src_we        = 1'b1;
              src_bal_d     = dep_sum[BAL_W-1:0];
              rsp_balance_d = dep_sum[BAL_W-1:0];
            end
          end
          OP_TRANSFER: begin
            if (!dest_hit || (dest_idx == sess_idx_q)) begin
              rsp_status_d = ST_NO_DEST;
            end else if (short_funds) begin
              rsp_status_d = ST_INSUFF;
            end else if (xfer_sum[BAL_W]) begin
              rsp_status_d = ST_OVERFLOW;
            end else begin
              src_we        = 1'b1;
              src_bal_d     = sess_bal - amt_q;
              dst_we        = 1'b1;
              dst_bal_d     = xfer_sum[BAL_W-1:0];
              rsp_balance_d = sess_bal - amt_q;
            end
          end
          OP_LOGOUT: state_d = S_IDLE;
          default:   rsp_status_d = ST_BAD_OP;
        endcase
      end

      default: state_d = S_IDLE;
    endcase

    // No session means no balance to report.
    if (state_d == S_IDLE) begin
      rsp_balance_d = '0;
    end
  end

  // FSM, command latch, timer and response registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      sess_idx_q    <= '0;
      op_q          <= '0;
      amt_q         <= '0;
      dest_q        <= '0;
      cnt_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_status_q  <= ST_OK;
      rsp_balance_q <= '0;
      cmd_ready_q   <= 1'b0;
      sess_act_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      sess_idx_q    <= sess_idx_d;
      op_q          <= op_d;
      amt_q         <= amt_d;
      dest_q        <= dest_d;
      cnt_q         <= cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_status_q  <= rsp_status_d;
      rsp_balance_q <= rsp_balance_d;
      cmd_ready_q   <= (state_d == S_MENU);
      sess_act_q    <= (state_d != S_IDLE);
    end
  end

  // Table control bits
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      lock_q  <= '0;
      fail_q  <= '0;
    end else begin
      if (prov_we) begin
        valid_q[prov_idx_i] <= 1'b1;
        lock_q[prov_idx_i]  <= 1'b0;
        fail_q[prov_idx_i]  <= '0;
      end
      if (fail_clr) begin
        fail_q[sess_idx_q] <= '0;
      end
      if (fail_inc) begin
        fail_q[sess_idx_q] <= fail_q[sess_idx_q] + FAIL_W'(1);
      end
      if (lock_set) begin
        lock_q[sess_idx_q] <= 1'b1;
      end
    end
  end

  // Table data; a transfer updates both balances in the same edge.
  always_ff @(posedge clk_i) begin
    if (prov_we) begin
      acc_q[prov_idx_i] <= prov_acc_i;
      pin_q[prov_idx_i] <= prov_pin_i;
      bal_q[prov_idx_i] <= prov_bal_i;
    end
    if (src_we) begin
      bal_q[sess_idx_q] <= src_bal_d;
    end
    if (dst_we) begin
      bal_q[dest_idx] <= dst_bal_d;
    end
  end

  assign cmd_ready_o      = cmd_ready_q;
  assign rsp_valid_o      = rsp_valid_q;
  assign rsp_status_o     = rsp_status_q;
  assign rsp_balance_o    = rsp_balance_q;
  assign session_active_o = sess_act_q;

endmodule
